delay_timer: RTL and testbench

DELAY_TIMER -- requirements
Module: delay_timer

---
 rtl/delay_timer.sv | 64 ++++++
 tb/tb_delay_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// delay_timer: NCH independent one-shot/periodic delay timers with a registered
// terminal-count pulse, sticky overrun flag and per-channel loadable period.
module delay_timer #(
   parameter int CBITS      = 14,
   parameter int NCH        = 4,
   parameter int DEF_PERIOD = 12500
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NCH-1:0]     start,
   input  logic [NCH-1:0]     stop,
   input  logic [NCH-1:0]     mode,
   input  logic [NCH-1:0]     load,
   input  logic [NCH*CBITS-1:0] period_in,
   input  logic [NCH-1:0]     err_clr,
   output logic [NCH-1:0]     sig,
   output logic [NCH-1:0]     busy,
   output logic [NCH-1:0]     err,
   output logic [NCH-1:0]     flg
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CBITS-1:0] cnt;
      logic [CBITS-1:0] period_reg;
      logic [0:0]       state;
      logic             sig_r;
      logic             err_r;
      logic             term;
      logic             over;
      assign term    = state == RUN && cnt >= period_reg;
      assign over    = state == RUN && cnt > period_reg;
      assign sig[i]  = sig_r;
      assign err[i]  = err_r;
      assign busy[i] = state == RUN;
      assign flg[i]  = cnt <= period_reg;
      // stop beats start, start beats a terminal event; err is tracked independently
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            cnt        <= '0;
            period_reg <= CBITS'(DEF_PERIOD);
            state      <= IDLE;
            sig_r      <= 1'b0;
            err_r      <= 1'b0;
         end else begin
            if (load[i]) period_reg <= period_in[i*CBITS +: CBITS];
            err_r <= over | (err_r & ~err_clr[i]);
            sig_r <= ~stop[i] & ~start[i] & term;
            if (stop[i]) begin
               state <= IDLE;
               cnt   <= '0;
            end else if (start[i]) begin
               state <= RUN;
               cnt   <= '0;
            end else if (term) begin
               state <= mode[i] ? RUN : IDLE;
               cnt   <= '0;
            end else if (state == RUN) begin
               cnt <= cnt + 1'b1;
            end
         end
   end
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed stimulus with a per-cycle expected-output scoreboard
// plus constant-valued timing checks for delay_timer.
module tb_delay_timer;
   localparam int CBITS = 14;
   localparam int NCH = 4;
   localparam int DEF_PERIOD = 12500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH-1:0] start = '0, stop = '0, mode = '0, load = '0, err_clr = '0;
   logic [NCH*CBITS-1:0] period_in = '0;
   logic [NCH-1:0] sig, busy, err, flg;

   delay_timer #(.CBITS(CBITS), .NCH(NCH), .DEF_PERIOD(DEF_PERIOD)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
      .period_in(period_in), .err_clr(err_clr), .sig(sig), .busy(busy), .err(err), .flg(flg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] sig, busy, err, flg;
   } exp_t;

   exp_t q[$];
   int passed = 0, total = 0;
   int m_cnt[NCH], m_per[NCH];
   bit m_run[NCH], m_sig[NCH], m_err[NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_per[i] = DEF_PERIOD; m_run[i] = 0; m_sig[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic set_load(input int ch, input int p);
      load[ch] = 1'b1;
      period_in[ch*CBITS +: CBITS] = CBITS'(p);
   endtask

   // predict next state from the driven inputs, push it, clock, pop and compare
   task automatic cycle();
      exp_t e, g;
      for (int i = 0; i < NCH; i++) begin
         bit t, ov;
         t = m_run[i] && m_cnt[i] >= m_per[i];
         ov = m_run[i] && m_cnt[i] > m_per[i];
         m_err[i] = ov || (m_err[i] && !err_clr[i]);
         m_sig[i] = 0;
         if (stop[i]) begin m_run[i] = 0; m_cnt[i] = 0; end
         else if (start[i]) begin m_run[i] = 1; m_cnt[i] = 0; end
         else if (t) begin m_sig[i] = 1; m_cnt[i] = 0; m_run[i] = mode[i]; end
         else if (m_run[i]) m_cnt[i]++;
         if (load[i]) m_per[i] = int'(period_in[i*CBITS +: CBITS]);
      end
      for (int i = 0; i < NCH; i++) begin
         e.sig[i] = m_sig[i]; e.busy[i] = m_run[i]; e.err[i] = m_err[i];
         e.flg[i] = m_cnt[i] <= m_per[i];
      end
      q.push_back(e);
      @(posedge clk); #1;
      start = '0; stop = '0; load = '0; err_clr = '0;
      g = q.pop_front();
      chk("sb_sig", sig, g.sig);
      chk("sb_busy", busy, g.busy);
      chk("sb_err", err, g.err);
      chk("sb_flg", flg, g.flg);
   endtask

   task automatic wait_sig(input int ch, input int lim, output int n);
      n = 0;
      do begin cycle(); n++; end while (!sig[ch] && n < lim);
      if (!sig[ch]) n = -1;
   endtask

   initial begin
      int n, c0, c3;
      model_reset();
      #12;
      chk("rst_sig", sig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_flg", flg, 4'hf);
      rst = 1'b0;

      // one-shot with default period
      start[0] = 1'b1;
      cycle();
      wait_sig(0, 13000, n);
      chk("oneshot_lat", n, DEF_PERIOD + 1);
      cycle();
      chk("oneshot_busy", busy[0], 0);
      chk("oneshot_err", err, 0);

      // periodic P=3 with load+start together, then stop mid-period
      mode[1] = 1'b1; set_load(1, 3); start[1] = 1'b1;
      cycle();
      wait_sig(1, 50, n); chk("per_first", n, 4);
      wait_sig(1, 50, n); chk("per_gap1", n, 4);
      wait_sig(1, 50, n); chk("per_gap2", n, 4);
      cycle(); cycle();
      stop[1] = 1'b1;
      cycle();
      chk("stop_busy", busy[1], 0);
      c0 = 0;
      repeat (10) begin cycle(); c0 += int'(sig[1]); end
      chk("stop_nopulse", c0, 0);

      // overrun: P=10 to cnt=8, load P=5
      set_load(2, 10); start[2] = 1'b1;
      cycle();
      repeat (8) cycle();
      set_load(2, 5);
      cycle();
      cycle();
      chk("ovr_err", err[2], 1);
      chk("ovr_sig", sig[2], 1);
      repeat (3) cycle();
      chk("ovr_sticky", err[2], 1);
      err_clr[2] = 1'b1;
      cycle();
      chk("ovr_clr", err[2], 0);

      // start+stop together, then restart mid-run
      start[0] = 1'b1; stop[0] = 1'b1;
      cycle();
      chk("ss_busy", busy[0], 0);
      chk("ss_sig", sig[0], 0);
      set_load(0, 10); start[0] = 1'b1;
      cycle();
      repeat (5) cycle();
      start[0] = 1'b1;
      cycle();
      wait_sig(0, 50, n);
      chk("restart_lat", n, 11);

      // P=0 periodic on ch0, P=2 periodic on ch3
      mode[0] = 1'b1; mode[3] = 1'b1;
      set_load(0, 0); set_load(3, 2); start[0] = 1'b1; start[3] = 1'b1;
      cycle();
      c0 = 0; c3 = 0;
      repeat (12) begin cycle(); c0 += int'(sig[0]); c3 += int'(sig[3]); end
      chk("p0_cont", c0, 12);
      chk("p2_count", c3, 4);

      // asynchronous reset mid-run, no clock edge in between
      #3 rst = 1'b1;
      #1;
      chk("arst_sig", sig, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err, 0);
      chk("arst_flg", flg, 4'hf);
      model_reset();
      #1 rst = 1'b0;
      mode = '0;
      start[1] = 1'b1;
      cycle();
      wait_sig(1, 13000, n);
      chk("arst_defper", n, DEF_PERIOD + 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
